// File: rtl/bip_pkg.sv
// Shared types and constants for the BIP-2 control unit: opcodes, FSM states,
// accumulator source selects and ALU operation codes.
package bip_pkg;

  localparam int DEF_PC_W = 11;
  localparam int DEF_IR_W = 16;
  localparam int OPC_W    = 5;

  typedef enum logic [OPC_W-1:0] {
    OP_HLT  = 5'h00,
    OP_STO  = 5'h01,
    OP_LD   = 5'h02,
    OP_LDI  = 5'h03,
    OP_ADD  = 5'h04,
    OP_ADDI = 5'h05,
    OP_SUB  = 5'h06,
    OP_SUBI = 5'h07,
    OP_BEQ  = 5'h08,
    OP_BNE  = 5'h09,
    OP_BGT  = 5'h0A,
    OP_BGE  = 5'h0B,
    OP_BLT  = 5'h0C,
    OP_BLE  = 5'h0D,
    OP_JMP  = 5'h0E
  } opcode_e;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_MEM,
    ST_EXEC,
    ST_HALT
  } state_e;

  localparam logic [1:0] ACC_SEL_ALU = 2'd0;
  localparam logic [1:0] ACC_SEL_MEM = 2'd1;
  localparam logic [1:0] ACC_SEL_IMM = 2'd2;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

endpackage

// File: rtl/bip_control_branch_eval.sv
// Branch condition evaluation for the BIP-2 control unit: combinational
// decode of a branch opcode against the stored Z/N flags.
import bip_pkg::*;

module bip_branch_eval (
  input  opcode_e opcode,
  input  logic    z,
  input  logic    n,
  output logic    taken
);

  always_comb begin
    taken = 1'b0;
    case (opcode)
      OP_BEQ:  taken = z;
      OP_BNE:  taken = !z;
      OP_BGT:  taken = !z && !n;
      OP_BGE:  taken = !n;
      OP_BLT:  taken = n;
      OP_BLE:  taken = n || z;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/bip_control.sv
// Multi-cycle FETCH/DECODE/MEM/EXEC/HALT sequencer for the BIP-2 core.
// Optional feature: define BIP_CTRL_ILLEGAL_TRAP_EN to trap undefined opcodes.
import bip_pkg::*;

module bip_control #(
  parameter int PC_W = DEF_PC_W,
  parameter int IR_W = DEF_IR_W
) (
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_req,
  input  logic            imem_rdy,
  input  logic [IR_W-1:0] imem_data,
  output logic [PC_W-1:0] dmem_addr,
  output logic            dmem_rd,
  output logic            dmem_wr,
  input  logic            dmem_rdy,
  output logic            alu_op,
  input  logic            alu_z,
  input  logic            alu_n,
  output logic            opnd_sel,
  output logic [1:0]      acc_sel,
  output logic            acc_wr,
  output logic [PC_W-1:0] imm,
`ifdef BIP_CTRL_ILLEGAL_TRAP_EN
  output logic            halted,
  output logic            illegal
`else
  output logic            halted
`endif
);

  state_e            state, state_next;
  logic [PC_W-1:0]   pc, pc_next;
  logic [IR_W-1:0]   ir, ir_next;
  logic              z_flag, z_next;
  logic              n_flag, n_next;
  logic [PC_W-1:0]   operand;
  opcode_e           opcode;
  logic              branch_taken;

  assign operand = ir[PC_W-1:0];
  assign opcode  = opcode_e'(ir[IR_W-1 -: OPC_W]);

  bip_branch_eval u_branch_eval (
    .opcode (opcode),
    .z      (z_flag),
    .n      (n_flag),
    .taken  (branch_taken)
  );

`ifdef BIP_CTRL_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_next;

  always_ff @(posedge clk) begin
    if (rst) illegal_q <= 1'b0;
    else     illegal_q <= illegal_next;
  end

  assign illegal = illegal_q && !rst;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_FETCH;
      pc     <= '0;
      ir     <= '0;
      z_flag <= 1'b0;
      n_flag <= 1'b0;
    end else begin
      state  <= state_next;
      pc     <= pc_next;
      ir     <= ir_next;
      z_flag <= z_next;
      n_flag <= n_next;
    end
  end

  // Address-like outputs are plain decodes of PC/IR, forced low during reset.
  assign imem_addr = rst ? '0 : pc;
  assign dmem_addr = rst ? '0 : operand;
  assign imm       = rst ? '0 : operand;
  assign halted    = !rst && (state == ST_HALT);

  always_comb begin
    state_next = state;
    pc_next    = pc;
    ir_next    = ir;
    z_next     = z_flag;
    n_next     = n_flag;
`ifdef BIP_CTRL_ILLEGAL_TRAP_EN
    illegal_next = illegal_q;
`endif
    imem_req = 1'b0;
    dmem_rd  = 1'b0;
    dmem_wr  = 1'b0;
    alu_op   = ALU_ADD;
    opnd_sel = 1'b0;
    acc_sel  = ACC_SEL_ALU;
    acc_wr   = 1'b0;

    case (state)
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_rdy) begin
          ir_next    = imem_data;
          pc_next    = pc + PC_W'(1);
          state_next = ST_DECODE;
        end
      end

      ST_DECODE: begin
        case (opcode)
          OP_HLT:                        state_next = ST_HALT;
          OP_LDI, OP_ADDI, OP_SUBI:      state_next = ST_EXEC;
          OP_LD, OP_ADD, OP_SUB, OP_STO: state_next = ST_MEM;
          OP_JMP: begin
            pc_next    = operand;
            state_next = ST_FETCH;
          end
          OP_BEQ, OP_BNE, OP_BGT, OP_BGE, OP_BLT, OP_BLE: begin
            if (branch_taken) pc_next = operand;
            state_next = ST_FETCH;
          end
          default: begin
`ifdef BIP_CTRL_ILLEGAL_TRAP_EN
            illegal_next = 1'b1;
            state_next   = ST_HALT;
`else
            state_next   = ST_FETCH;
`endif
          end
        endcase
      end

      // Requests stay asserted until dmem_rdy; acc_wr and flags wait for it too.
      ST_MEM: begin
        if (opcode == OP_STO) dmem_wr = 1'b1;
        else                  dmem_rd = 1'b1;
        if (opcode == OP_LD)  acc_sel = ACC_SEL_MEM;
        if (opcode == OP_SUB) alu_op  = ALU_SUB;
        if (dmem_rdy) begin
          acc_wr = (opcode != OP_STO);
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            z_next = alu_z;
            n_next = alu_n;
          end
          state_next = ST_FETCH;
        end
      end

      ST_EXEC: begin
        acc_wr = 1'b1;
        if (opcode == OP_LDI) begin
          acc_sel = ACC_SEL_IMM;
        end else begin
          opnd_sel = 1'b1;
          alu_op   = (opcode == OP_SUBI) ? ALU_SUB : ALU_ADD;
          z_next   = alu_z;
          n_next   = alu_n;
        end
        state_next = ST_FETCH;
      end

      ST_HALT: state_next = ST_HALT;

      default: state_next = ST_FETCH;
    endcase

    if (rst) begin
      imem_req = 1'b0;
      dmem_rd  = 1'b0;
      dmem_wr  = 1'b0;
      alu_op   = ALU_ADD;
      opnd_sel = 1'b0;
      acc_sel  = ACC_SEL_ALU;
      acc_wr   = 1'b0;
    end
  end

endmodule
